// File: rtl/hpm_event_ovf.sv
// Event-select registers, counter gating/filtering and Sscofpmf-style overflow/LCOF tracking.
// Optional feature macro: HPM_MODEFILTER_EN adds per-counter MINH/SINH/UINH privilege filtering.
module hpm_event_ovf #(
    parameter int XLEN     = 64,
    parameter int COUNTERS = 32,
    parameter int EVSEL_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CSRMWriteM,
    input  logic [11:0]         CSRAdrM,
    input  logic [XLEN-1:0]     CSRWriteValM,
    input  logic [31:0]         RawEventM,
    input  logic [COUNTERS-1:0] CounterAllOnesM,
    input  logic [31:0]         MCOUNTINHIBIT_REGW,
    input  logic                DebugStopCount_REGW,
    input  logic [1:0]          PrivilegeModeW,
    input  logic                MIPClearLCOFM,
    output logic [COUNTERS-1:0] CountIncM,
    output logic [COUNTERS-1:0] OverflowM,
    output logic [XLEN-1:0]     HPMEventReadValM,
    output logic                HPMEventHitM,
    output logic                LCOFIPendingM
);

    // RV64 keeps the flags in the top nibble of mhpmevent; RV32 moves them to mhpmeventh.
    localparam int          FLAG_LSB  = (XLEN == 64) ? 60 : 28;
    localparam logic [11:0] SEL_BASE  = 12'h320;
    localparam logic [11:0] FLAG_BASE = (XLEN == 64) ? 12'h320 : 12'h720;

    logic [EVSEL_W-1:0]  sel_q [3:COUNTERS-1];
    logic [COUNTERS-1:3] of_q;
    logic [COUNTERS-1:3] wr_sel;
    logic [COUNTERS-1:3] wr_flag;
    logic [COUNTERS-1:3] wrap;
    logic [COUNTERS-1:3] mode_inh;
    logic [COUNTERS-1:0] gate;
    logic [3:0]          flags [3:COUNTERS-1];
    logic [4:0]          adr_idx;
    logic                sel_region;
    logic                flag_region;
    logic                set_lcof;
    logic                unused_ok;

    function automatic logic event_bit(input logic [EVSEL_W-1:0] s, input logic [31:0] raw);
        logic [31:0] idx;
        idx = 32'(s);
        event_bit = (idx != 32'd0) && (idx < 32'd32) && raw[idx[4:0]];
    endfunction

    assign gate = ~MCOUNTINHIBIT_REGW[COUNTERS-1:0] & {COUNTERS{~DebugStopCount_REGW}};

    always_comb begin
        wr_sel  = '0;
        wr_flag = '0;
        for (int i = 3; i < COUNTERS; i++) begin
            wr_sel[i]  = CSRMWriteM && (CSRAdrM == SEL_BASE + 12'(i));
            wr_flag[i] = CSRMWriteM && (CSRAdrM == FLAG_BASE + 12'(i));
        end
    end

    always_comb begin
        CountIncM    = '0;
        CountIncM[0] = gate[0];
        CountIncM[2] = RawEventM[2] & gate[2];
        for (int i = 3; i < COUNTERS; i++) begin
            CountIncM[i] = event_bit(sel_q[i], RawEventM) & gate[i] & ~mode_inh[i];
        end
    end

    assign wrap     = CountIncM[COUNTERS-1:3] & CounterAllOnesM[COUNTERS-1:3];
    // Only a wrap on a counter whose OF is still clear raises the interrupt.
    assign set_lcof = |(wrap & ~of_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            of_q <= '0;
            for (int i = 3; i < COUNTERS; i++) begin
                sel_q[i] <= '0;
            end
        end else begin
            for (int i = 3; i < COUNTERS; i++) begin
                if (wr_sel[i]) begin
                    sel_q[i] <= CSRWriteValM[EVSEL_W-1:0];
                end
                if (wrap[i]) begin
                    of_q[i] <= 1'b1;
                end else if (wr_flag[i]) begin
                    of_q[i] <= CSRWriteValM[FLAG_LSB+3];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LCOFIPendingM <= 1'b0;
        end else if (set_lcof) begin
            LCOFIPendingM <= 1'b1;
        end else if (MIPClearLCOFM) begin
            LCOFIPendingM <= 1'b0;
        end
    end

`ifdef HPM_MODEFILTER_EN
    logic [COUNTERS-1:3] minh_q;
    logic [COUNTERS-1:3] sinh_q;
    logic [COUNTERS-1:3] uinh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            minh_q <= '0;
            sinh_q <= '0;
            uinh_q <= '0;
        end else begin
            for (int i = 3; i < COUNTERS; i++) begin
                if (wr_flag[i]) begin
                    minh_q[i] <= CSRWriteValM[FLAG_LSB+2];
                    sinh_q[i] <= CSRWriteValM[FLAG_LSB+1];
                    uinh_q[i] <= CSRWriteValM[FLAG_LSB];
                end
            end
        end
    end

    always_comb begin
        mode_inh = '0;
        for (int i = 3; i < COUNTERS; i++) begin
            case (PrivilegeModeW)
                2'b11:   mode_inh[i] = minh_q[i];
                2'b01:   mode_inh[i] = sinh_q[i];
                2'b00:   mode_inh[i] = uinh_q[i];
                default: mode_inh[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        for (int i = 3; i < COUNTERS; i++) begin
            flags[i] = {of_q[i], minh_q[i], sinh_q[i], uinh_q[i]};
        end
    end
`else
    assign mode_inh = '0;

    always_comb begin
        for (int i = 3; i < COUNTERS; i++) begin
            flags[i] = {of_q[i], 3'b000};
        end
    end
`endif

    // Whole 0x323..0x33F (and 0x723.. on RV32) window hits, even past COUNTERS.
    assign adr_idx     = CSRAdrM[4:0];
    assign sel_region  = (CSRAdrM[11:5] == SEL_BASE[11:5]) && (adr_idx >= 5'd3);
    assign flag_region = (CSRAdrM[11:5] == FLAG_BASE[11:5]) && (adr_idx >= 5'd3);
    assign HPMEventHitM = sel_region | flag_region;

    always_comb begin
        HPMEventReadValM = '0;
        for (int i = 3; i < COUNTERS; i++) begin
            if (adr_idx == 5'(i)) begin
                if (sel_region) begin
                    HPMEventReadValM[EVSEL_W-1:0] = sel_q[i];
                end
                if (flag_region) begin
                    HPMEventReadValM[FLAG_LSB +: 4] = flags[i];
                end
            end
        end
    end

    assign OverflowM = {of_q, 3'b000};

    assign unused_ok = ^{CSRWriteValM, MCOUNTINHIBIT_REGW, CounterAllOnesM, PrivilegeModeW, gate};

endmodule

// File: tb/tb_hpm_event_ovf.sv
// Bench for hpm_event_ovf: an RV64/32-counter instance and an RV32/8-counter/6-bit-select instance.
module tb_hpm_event_ovf;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [11:0] adr;
    logic [63:0] wval;
    logic [31:0] raw;
    logic [31:0] allones;
    logic [31:0] inhibit;
    logic        dstop;
    logic [1:0]  priv;
    logic        mclr;

    logic [31:0] cnt64, ovf64;
    logic [63:0] rd64;
    logic        hit64, lcof64;
    logic [7:0]  cnt32, ovf32;
    logic [31:0] rd32;
    logic        hit32, lcof32;

    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int          n_checks;
    int          n_pass;

    hpm_event_ovf #(.XLEN(64), .COUNTERS(32), .EVSEL_W(5)) dut (
        .clk(clk), .reset(reset), .CSRMWriteM(wr), .CSRAdrM(adr), .CSRWriteValM(wval),
        .RawEventM(raw), .CounterAllOnesM(allones), .MCOUNTINHIBIT_REGW(inhibit),
        .DebugStopCount_REGW(dstop), .PrivilegeModeW(priv), .MIPClearLCOFM(mclr),
        .CountIncM(cnt64), .OverflowM(ovf64), .HPMEventReadValM(rd64),
        .HPMEventHitM(hit64), .LCOFIPendingM(lcof64)
    );

    hpm_event_ovf #(.XLEN(32), .COUNTERS(8), .EVSEL_W(6)) dut32 (
        .clk(clk), .reset(reset), .CSRMWriteM(wr), .CSRAdrM(adr), .CSRWriteValM(wval[31:0]),
        .RawEventM(raw), .CounterAllOnesM(allones[7:0]), .MCOUNTINHIBIT_REGW(inhibit),
        .DebugStopCount_REGW(dstop), .PrivilegeModeW(priv), .MIPClearLCOFM(mclr),
        .CountIncM(cnt32), .OverflowM(ovf32), .HPMEventReadValM(rd32),
        .HPMEventHitM(hit32), .LCOFIPendingM(lcof32)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] v);
        wr   = 1'b1;
        adr  = a;
        wval = v;
        tick();
        wr   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        reset = 1'b0;
        adr   = 12'h323;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64 !== exp[31:0]) $display("FAIL reset_countinc: got %h want %h", cnt64, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL reset_overflow: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL reset_lcof: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL reset_read323: got %h want %h", rd64, exp); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (hit64 !== exp[0]) $display("FAIL reset_hit323: got %b want %b", hit64, exp[0]); else n_pass++;
    endtask

    task automatic test_event_select();
        csr_write(12'h323, 64'h5);
        exp_q.push_back(64'h5);
        adr = 12'h323;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL evsel_readback: got %h want %h", rd64, exp); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(64'h1);
            raw = 32'h20;
            #1;
            exp = exp_q.pop_front(); n_checks++;
            if (cnt64[3] !== exp[0]) $display("FAIL evsel_pulse%0d: got %b want %b", k, cnt64[3], exp[0]); else n_pass++;
            tick();
        end
        exp_q.push_back(64'h0);
        raw = 32'h0;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[3] !== exp[0]) $display("FAIL evsel_after: got %b want %b", cnt64[3], exp[0]); else n_pass++;
        exp_q.push_back(64'h1);
        raw     = 32'h20;
        inhibit = 32'h8;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[3:0] !== exp[3:0]) $display("FAIL evsel_inhibit: got %h want %h", cnt64[3:0], exp[3:0]); else n_pass++;
        exp_q.push_back(64'h0);
        inhibit = 32'h0;
        dstop   = 1'b1;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64 !== exp[31:0]) $display("FAIL evsel_dstop: got %h want %h", cnt64, exp[31:0]); else n_pass++;
        dstop = 1'b0;
        raw   = 32'h0;
        tick();
    endtask

    task automatic test_mode_filter();
        csr_write(12'h324, 64'h4000_0000_0000_0007);
        raw  = 32'h80;
        priv = 2'b11;
        adr  = 12'h324;
`ifdef HPM_MODEFILTER_EN
        exp_q.push_back(64'h4000_0000_0000_0007);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL mode_readback: got %h want %h", rd64, exp); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[4] !== exp[0]) $display("FAIL mode_m_inhibited: got %b want %b", cnt64[4], exp[0]); else n_pass++;
        priv = 2'b00;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[4] !== exp[0]) $display("FAIL mode_u_counts: got %b want %b", cnt64[4], exp[0]); else n_pass++;
        priv = 2'b01;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[4] !== exp[0]) $display("FAIL mode_s_counts: got %b want %b", cnt64[4], exp[0]); else n_pass++;
`else
        exp_q.push_back(64'h7);
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL mode_readback: got %h want %h", rd64, exp); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[4] !== exp[0]) $display("FAIL mode_m_counts: got %b want %b", cnt64[4], exp[0]); else n_pass++;
`endif
        priv = 2'b11;
        raw  = 32'h0;
        tick();
    endtask

    task automatic test_overflow();
        raw     = 32'h20;
        allones = 32'h8;
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64[3] !== exp[0]) $display("FAIL ovf_inc: got %b want %b", cnt64[3], exp[0]); else n_pass++;
        exp_q.push_back(64'h8);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h8000_0000_0000_0005);
        tick();
        raw     = 32'h0;
        allones = 32'h0;
        adr     = 12'h323;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL ovf_of3: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL ovf_lcof: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL ovf_read323: got %h want %h", rd64, exp); else n_pass++;
        exp_q.push_back(64'h0);
        mclr = 1'b1;
        tick();
        mclr = 1'b0;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL ovf_clear: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h8);
        raw     = 32'h20;
        allones = 32'h8;
        tick();
        raw     = 32'h0;
        allones = 32'h0;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL ovf_rewrap_nolcof: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL ovf_rewrap_of: got %h want %h", ovf64, exp[31:0]); else n_pass++;
    endtask

    task automatic test_set_vs_clear();
        csr_write(12'h323, 64'h0);
        exp_q.push_back(64'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL svc_of_cleared: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        csr_write(12'h325, 64'h5);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h20);
        raw     = 32'h20;
        allones = 32'h20;
        mclr    = 1'b1;
        tick();
        raw     = 32'h0;
        allones = 32'h0;
        mclr    = 1'b0;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL svc_set_wins: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL svc_of5: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        exp_q.push_back(64'h0);
        raw     = 32'h20;
        allones = 32'h20;
        mclr    = 1'b1;
        tick();
        raw     = 32'h0;
        allones = 32'h0;
        mclr    = 1'b0;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL svc_clear_wins: got %b want %b", lcof64, exp[0]); else n_pass++;
    endtask

    task automatic test_boundary();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        adr = 12'h322;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit64 !== exp[0]) $display("FAIL bnd_hit322: got %b want %b", hit64, exp[0]); else n_pass++;
        adr = 12'h33F;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit64 !== exp[0]) $display("FAIL bnd_hit33f: got %b want %b", hit64, exp[0]); else n_pass++;
        adr = 12'h340;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit64 !== exp[0]) $display("FAIL bnd_hit340: got %b want %b", hit64, exp[0]); else n_pass++;
        adr = 12'h723;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit64 !== exp[0]) $display("FAIL bnd_hit723_rv64: got %b want %b", hit64, exp[0]); else n_pass++;

        csr_write(12'h33F, 64'h8000_0000_0000_001F);
        exp_q.push_back(64'h8000_0000_0000_001F);
        exp_q.push_back(64'h8000_0020);
        exp_q.push_back(64'h0);
        adr = 12'h33F;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd64 !== exp) $display("FAIL bnd_read33f: got %h want %h", rd64, exp); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL bnd_of31_write: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL bnd_write_no_lcof: got %b want %b", lcof64, exp[0]); else n_pass++;

        csr_write(12'h32A, 64'h5);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        adr = 12'h32A;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit32 !== exp[0]) $display("FAIL bnd_unimpl_hit: got %b want %b", hit32, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (rd32 !== exp[31:0]) $display("FAIL bnd_unimpl_read: got %h want %h", rd32, exp[31:0]); else n_pass++;
        adr = 12'h72A;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (hit32 !== exp[0]) $display("FAIL bnd_unimpl_hith: got %b want %b", hit32, exp[0]); else n_pass++;

        csr_write(12'h326, 64'h25);
        exp_q.push_back(64'h0);
        raw = 32'hFFFF_FFFF;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt32[6] !== exp[0]) $display("FAIL bnd_sel_ge32: got %b want %b", cnt32[6], exp[0]); else n_pass++;
        csr_write(12'h326, 64'h5);
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt32[6] !== exp[0]) $display("FAIL bnd_sel_lt32: got %b want %b", cnt32[6], exp[0]); else n_pass++;
        raw = 32'h0;
        tick();
    endtask

    task automatic test_rv32();
        csr_write(12'h723, 64'h0);
        csr_write(12'h725, 64'h0);
        exp_q.push_back(64'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (ovf32 !== exp[7:0]) $display("FAIL rv32_of_cleared: got %h want %h", ovf32, exp[7:0]); else n_pass++;
        csr_write(12'h323, 64'h5);
        csr_write(12'h723, 64'h8000_0000);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h5);
        exp = exp_q.pop_front(); n_checks++;
        if (ovf32 !== exp[7:0]) $display("FAIL rv32_of_write: got %h want %h", ovf32, exp[7:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof32 !== exp[0]) $display("FAIL rv32_write_no_lcof: got %b want %b", lcof32, exp[0]); else n_pass++;
        adr = 12'h723;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd32 !== exp[31:0]) $display("FAIL rv32_read723: got %h want %h", rd32, exp[31:0]); else n_pass++;
        adr = 12'h323;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd32 !== exp[31:0]) $display("FAIL rv32_read323: got %h want %h", rd32, exp[31:0]); else n_pass++;
        csr_write(12'h723, 64'h0);
        exp_q.push_back(64'h0);
        exp = exp_q.pop_front(); n_checks++;
        if (ovf32 !== exp[7:0]) $display("FAIL rv32_of_clear: got %h want %h", ovf32, exp[7:0]); else n_pass++;
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h1);
        raw     = 32'h20;
        allones = 32'h8;
        csr_write(12'h723, 64'h0);
        raw     = 32'h0;
        allones = 32'h0;
        adr     = 12'h723;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (rd32 !== exp[31:0]) $display("FAIL rv32_wrap_beats_write: got %h want %h", rd32, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof32 !== exp[0]) $display("FAIL rv32_wrap_lcof: got %b want %b", lcof32, exp[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        csr_write(12'h325, 64'h5);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        raw     = 32'h20;
        allones = 32'h20;
        reset   = 1'b1;
        #1;
        exp = exp_q.pop_front(); n_checks++;
        if (ovf64 !== exp[31:0]) $display("FAIL rstmid_of: got %h want %h", ovf64, exp[31:0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL rstmid_lcof64: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (lcof32 !== exp[0]) $display("FAIL rstmid_lcof32: got %b want %b", lcof32, exp[0]); else n_pass++;
        tick();
        reset   = 1'b0;
        raw     = 32'h0;
        allones = 32'h0;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        tick();
        exp = exp_q.pop_front(); n_checks++;
        if (lcof64 !== exp[0]) $display("FAIL rstmid_no_late_lcof: got %b want %b", lcof64, exp[0]); else n_pass++;
        exp = exp_q.pop_front(); n_checks++;
        if (cnt64 !== exp[31:0]) $display("FAIL rstmid_countinc: got %h want %h", cnt64, exp[31:0]); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        wr       = 1'b0;
        adr      = 12'h0;
        wval     = 64'h0;
        raw      = 32'h0;
        allones  = 32'h0;
        inhibit  = 32'h0;
        dstop    = 1'b0;
        priv     = 2'b11;
        mclr     = 1'b0;
        test_reset();
        test_event_select();
        test_mode_filter();
        test_overflow();
        test_set_vs_clear();
        test_boundary();
        test_rv32();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hpm_event_ovf.md
Name: hpm_event_ovf

Overview:
- Sits directly upstream of the performance-counter CSR block.
- Holds the mhpmevent3..N configuration registers and selects each programmable counter's event source.
- Applies inhibit, debug-stop and privilege-mode filtering, and drives the per-counter increment enables into the counter block.
- Detects counter wrap and maintains the OF bits and the local counter-overflow interrupt pending (LCOFIP, Sscofpmf style).

Parameters:
- XLEN, 64, register width (32 or 64).
- COUNTERS, 32, number of counters implemented (3..32).
- EVSEL_W, 5, width of the event-select field.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- CSRMWriteM  in  1  M-mode CSR write strobe, M stage
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  CSR write data
- RawEventM  in  32  raw event sources, indexed by event select; bit 0 unused
- CounterAllOnesM  in  COUNTERS  full 64-bit counter i currently equals all ones
- MCOUNTINHIBIT_REGW  in  32  counter inhibit bits
- DebugStopCount_REGW  in  1  debug-mode counter stop
- PrivilegeModeW  in  2  current privilege mode
- MIPClearLCOFM  in  1  software clear of mip.LCOFIP
- CountIncM  out  COUNTERS  increment enable per counter
- OverflowM  out  COUNTERS  OF bits; bits 0..2 are always 0
- HPMEventReadValM  out  XLEN  read data for an addressed mhpmevent/mhpmeventh
- HPMEventHitM  out  1  CSRAdrM decodes to an implemented event register
- LCOFIPendingM  out  1  overflow interrupt pending

Behaviour:
- Event register i (3 <= i < COUNTERS) is at 0x320+i.
  - RV64 layout: bit63 OF, bit62 MINH, bit61 SINH, bit60 UINH, [EVSEL_W-1:0] SEL; all other bits read 0.
  - RV32 layout: SEL sits in 0x320+i. OF/MINH/SINH/UINH sit at bits 31:28 of mhpmeventh at 0x720+i.
  - Addresses for counter indices >= COUNTERS decode as a hit and read 0; writes to them are ignored.
- Reset (async): every SEL, OF and xINH bit is 0; LCOFIPendingM = 0.
- Combinational outputs follow from the reset state: CountIncM = {..,0,0,0 bit2 gated,bit0 gated}, OverflowM = 0, HPMEventReadValM = 0.
- A write takes effect on the next clk edge.
- Define Gate_i = ~MCOUNTINHIBIT_REGW[i] & ~DebugStopCount_REGW.
- CountIncM is combinational:
  - CountIncM[0] = Gate_0.
  - CountIncM[1] = 0.
  - CountIncM[2] = RawEventM[2] & Gate_2.
  - For i >= 3: CountIncM[i] = (SEL_i != 0) & RawEventM[SEL_i] & Gate_i & ~ModeInh_i.
  - ModeInh_i = MINH_i in M mode, SINH_i in S mode, UINH_i in U mode.
  - If SEL_i >= 32, the event is treated as 0.
- Overflow for i >= 3: Wrap_i = CountIncM[i] & CounterAllOnesM[i].
  - Next OF_i = 1 if Wrap_i, else the CSR write value if counter i's register is written, else the held value.
  - A wrap and a CSR write to the same register in the same cycle: the write sets SEL/xINH, but OF ends at 1 (the wrap wins).
- Interrupt: SetLCOF = OR over i of (Wrap_i & ~OF_i). A wrap while OF_i is already 1 does not set LCOF.
  - LCOFIPendingM is a flop, so latency from wrap to pending is 1 cycle.
  - Next value = SetLCOF ? 1 : (MIPClearLCOFM ? 0 : hold). Set beats clear in the same cycle.
- Read: HPMEventReadValM returns the addressed register's fields in the layout above, and 0 when HPMEventHitM = 0.
- Reset asserted mid-operation clears all state immediately, including a pending wrap in flight.

Optional Feature:
- Macro: HPM_MODEFILTER_EN.
- When defined: MINH/SINH/UINH are implemented, readable and writable, and filter CountIncM as above.
- When undefined: no flops exist for the xINH bits, they read 0, writes to them are ignored, and ModeInh_i = 0.

Test Plan:
1. Reset: assert reset for 2 cycles, then release with RawEventM=0 and inhibit=0 -> CountIncM=0x1, OverflowM=0, LCOFIPendingM=0, and reads of 0x323 return 0.
2. Event select: write 0x323=0x0000_0000_0000_0005, then pulse RawEventM[5] for 3 cycles -> CountIncM[3]=1 exactly for those 3 cycles; with MCOUNTINHIBIT_REGW[3]=1 -> 0.
3. Mode filter (macro on): write 0x324=0x4000_0000_0000_0007 (MINH) with RawEventM[7]=1 -> CountIncM[4]=0 in M mode and 1 in U mode. With the macro off, the register reads back 0x7 and CountIncM[4]=1 in M mode.
4. Overflow: SEL_3=5, RawEventM[5]=1, CounterAllOnesM[3]=1 for 1 cycle -> next cycle OverflowM[3]=1, LCOFIPendingM=1, and 0x323 reads bit63 set.
5. Set-vs-clear: OF_3 held at 0, wrap on counter 5 in the same cycle as MIPClearLCOFM=1 -> LCOFIPendingM=1. Then a second wrap on counter 5 (OF_5=1) together with a clear -> LCOFIPendingM=0.
6. RV32: write 0x723=0x8000_0000 -> OverflowM[3]=1, no LCOF; write 0x723=0 in the same cycle as a wrap -> OF_3 reads 1.
